// File: rtl/decode_pkg.sv
// decode_pkg: opcode/cond/state encodings, ALU op codes and branch-target ROM contents.
package decode_pkg;
    typedef enum logic [2:0] {
        op_add = 3'b000,
        op_sub = 3'b001,
        op_and = 3'b010,
        op_cmp = 3'b011,
        op_ldi = 3'b100,
        op_lw  = 3'b101,
        op_sw  = 3'b110,
        op_ctl = 3'b111
    } opcode_e;
    typedef enum logic [1:0] {
        cond_bra  = 2'b00,
        cond_bz   = 2'b01,
        cond_bn   = 2'b10,
        cond_halt = 2'b11
    } cond_e;
    typedef enum logic {
        st_run  = 1'b0,
        st_halt = 1'b1
    } state_e;
    localparam logic [1:0] alu_add = 2'b00;
    localparam logic [1:0] alu_sub = 2'b01;
    localparam logic [1:0] alu_and = 2'b10;
    localparam int lut_entries = 16;
    localparam logic [7:0] branch_targets [0:lut_entries-1] = '{
        8'h00, 8'h12, 8'h24, 8'h36, 8'h48, 8'h5A, 8'h6C, 8'h7E,
        8'h81, 8'h93, 8'hA5, 8'hB7, 8'hC9, 8'hDB, 8'hED, 8'hFF
    };
endpackage

// File: rtl/decode_unit_branch_lut.sv
// branch_lut: combinational ROM mapping a 4-bit branch index to its target address.
module branch_lut
    import decode_pkg::*;
#(
    parameter int reg_width = 8
) (
    input  logic [3:0]           idx,
    output logic [reg_width-1:0] target
);
    assign target = reg_width'(branch_targets[idx]);
endmodule

// File: rtl/decode_unit.sv
// decode_unit: instruction decode, branch resolution from registered flags, RUN/HALT FSM, retired-instruction counter.
module decode_unit
    import decode_pkg::*;
#(
    parameter int instr_width = 9,
    parameter int reg_width   = 8,
    parameter int lut_depth   = 16,
    parameter int count_width = 16
) (
    input  logic                   clk,
    input  logic                   start,
    input  logic [instr_width-1:0] instr,
    input  logic                   alu_zero,
    input  logic                   alu_neg,
    output logic                   branch,
    output logic                   taken,
    output logic [reg_width-1:0]   target,
    output logic [1:0]             alu_op,
    output logic [2:0]             rd_addr,
    output logic [2:0]             rs_addr,
    output logic [reg_width-1:0]   imm,
    output logic                   imm_sel,
    output logic                   reg_write,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   done,
    output logic [count_width-1:0] instr_count
);
    opcode_e op;
    cond_e cond;
    state_e state, state_next;
    logic z_flag, n_flag, active, is_branch, is_halt, flag_load;
    assign op = opcode_e'(instr[instr_width-1 -: 3]);
    assign cond = cond_e'(instr[5:4]);
    assign active = (state == st_run) && !start;
    assign is_branch = (op == op_ctl) && (cond != cond_halt);
    assign is_halt = (op == op_ctl) && (cond == cond_halt);
    assign flag_load = active && (op == op_add || op == op_sub || op == op_and || op == op_cmp);
    branch_lut #(.reg_width(reg_width)) u_lut (
        .idx    (instr[3:0]),
        .target (target)
    );
    always_comb begin
        alu_op    = (op == op_sub || op == op_cmp) ? alu_sub : (op == op_and) ? alu_and : alu_add;
        rd_addr   = (op == op_ldi) ? 3'd0 : instr[5:3];
        rs_addr   = instr[2:0];
        imm       = reg_width'(instr[5:0]);
        imm_sel   = (op == op_ldi);
        reg_write = active && (op == op_add || op == op_sub || op == op_and || op == op_ldi || op == op_lw);
        mem_read  = active && (op == op_lw);
        mem_write = active && (op == op_sw);
        branch    = active && is_branch;
        taken     = branch && (cond == cond_bra || (cond == cond_bz && z_flag) || (cond == cond_bn && n_flag));
    end
    always_comb begin
        state_next = state;
        if (state == st_run && is_halt) state_next = st_halt;
    end
    always_ff @(posedge clk) begin
        if (start) begin
            state       <= st_run;
            z_flag      <= 1'b0;
            n_flag      <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= state_next;
            if (flag_load) begin
                z_flag <= alu_zero;
                n_flag <= alu_neg;
            end
            if (state == st_run && instr_count != '1) instr_count <= instr_count + 1'b1;
        end
    end
    assign done = (state == st_halt);
endmodule
